// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: opcode fields, fetch metadata carried
// alongside each instruction, and the sequential PC step.
package rv_pkg;

  localparam logic [4:0]  OP_BRANCH   = 5'b11000;
  localparam logic [4:0]  OP_JAL      = 5'b11011;
  localparam logic [4:0]  OP_JALR     = 5'b11001;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fetch_meta_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC generator: follows branch_control's prediction, resolves it in EX,
// redirects and flushes on a wrong guess, and trains the 2-bit predictor.
module fetch_redirect_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_stall,
  output logic [31:0]          o_pc,
  input  logic                 i_pred_taken,
  input  logic [31:0]          i_pred_pc,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_is_branch,
  input  logic                 i_ex_is_jalr,
  input  logic                 i_ex_actual_taken,
  input  logic [31:0]          i_ex_target,
  output logic                 o_flush,
  output logic                 o_update_en,
  output logic                 o_actual_taken,
  output logic [31:0]          o_update_pc,
  output logic [CNT_WIDTH-1:0] o_branch_count,
  output logic [CNT_WIDTH-1:0] o_mispredict_count
);

  logic [31:0] r_pc;
  fetch_meta_t r_sh_id;
  fetch_meta_t r_sh_ex;

  logic        w_ex_live;
  logic        w_br_wrong;
  logic        w_mispredict;
  logic        w_update_en;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_next_pc;

  // A conditional branch is wrong if the direction differs, or if it was
  // taken to a different place than predicted. JALR is never predicted.
  assign w_ex_live   = r_sh_ex.v & i_ex_valid;
  assign w_br_wrong  = (r_sh_ex.pred_taken != i_ex_actual_taken) |
                       (i_ex_actual_taken & (r_sh_ex.pred_pc != i_ex_target));
  assign w_mispredict = w_ex_live & ((i_ex_is_branch & w_br_wrong) | i_ex_is_jalr);
  assign w_update_en  = w_ex_live & i_ex_is_branch;

  assign w_redirect_pc = (i_ex_actual_taken | i_ex_is_jalr) ? i_ex_target
                                                            : next_seq_pc(r_sh_ex.pc);

  always_comb begin
    if (w_mispredict) begin
      w_next_pc = w_redirect_pc;
    end else if (i_stall) begin
      w_next_pc = r_pc;
    end else if (i_pred_taken) begin
      w_next_pc = i_pred_pc;
    end else begin
      w_next_pc = next_seq_pc(r_pc);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Flush beats stall; a stall freezes IF/ID and pushes a bubble into EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_id <= '0;
      r_sh_ex <= '0;
    end else if (w_mispredict) begin
      r_sh_id.v <= 1'b0;
      r_sh_ex.v <= 1'b0;
    end else if (i_stall) begin
      r_sh_ex.v <= 1'b0;
    end else begin
      r_sh_id <= '{v: 1'b1, pc: r_pc, pred_taken: i_pred_taken, pred_pc: i_pred_pc};
      r_sh_ex <= r_sh_id;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_update_en),
    .o_count (o_branch_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_mispredict),
    .o_count (o_mispredict_count)
  );

  assign o_pc           = r_pc;
  assign o_flush        = w_mispredict;
  assign o_update_en    = w_update_en;
  assign o_actual_taken = w_update_en & i_ex_actual_taken;
  assign o_update_pc    = w_update_en ? r_sh_ex.pc : 32'h0;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: directed scenarios then random
// traffic, with a second small-counter instance sharing the same stimulus.
module tb_fetch_redirect_unit;

  logic        clk;
  logic        reset;
  logic        i_stall;
  logic        i_pred_taken;
  logic [31:0] i_pred_pc;
  logic        i_ex_valid;
  logic        i_ex_is_branch;
  logic        i_ex_is_jalr;
  logic        i_ex_actual_taken;
  logic [31:0] i_ex_target;

  logic [31:0] o_pc, s_pc;
  logic        o_flush, s_flush;
  logic        o_update_en, s_update_en;
  logic        o_actual_taken, s_actual_taken;
  logic [31:0] o_update_pc, s_update_pc;
  logic [31:0] o_branch_count, o_mispredict_count;
  logic [1:0]  s_branch_count, s_mispredict_count;

  fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .i_stall(i_stall), .o_pc(o_pc),
    .i_pred_taken(i_pred_taken), .i_pred_pc(i_pred_pc),
    .i_ex_valid(i_ex_valid), .i_ex_is_branch(i_ex_is_branch),
    .i_ex_is_jalr(i_ex_is_jalr), .i_ex_actual_taken(i_ex_actual_taken),
    .i_ex_target(i_ex_target), .o_flush(o_flush), .o_update_en(o_update_en),
    .o_actual_taken(o_actual_taken), .o_update_pc(o_update_pc),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
  );

  fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_WIDTH(2)) dutSmall (
    .clk(clk), .reset(reset), .i_stall(i_stall), .o_pc(s_pc),
    .i_pred_taken(i_pred_taken), .i_pred_pc(i_pred_pc),
    .i_ex_valid(i_ex_valid), .i_ex_is_branch(i_ex_is_branch),
    .i_ex_is_jalr(i_ex_is_jalr), .i_ex_actual_taken(i_ex_actual_taken),
    .i_ex_target(i_ex_target), .o_flush(s_flush), .o_update_en(s_update_en),
    .o_actual_taken(s_actual_taken), .o_update_pc(s_update_pc),
    .o_branch_count(s_branch_count), .o_mispredict_count(s_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        upd;
    logic        act;
    logic [31:0] updPc;
    logic [31:0] bc;
    logic [31:0] mc;
    logic [1:0]  mcSmall;
    logic [1:0]  bcSmall;
  } exp_t;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          pt;
    logic [31:0] ppc;
  } meta_t;

  exp_t  expQ[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: one fetch PC and the two in-flight instruction slots.
  logic [31:0] mPc;
  meta_t       mId, mEx;
  longint      mBranches, mMispredicts;

  function automatic logic [31:0] sat(input longint n, input longint maxv);
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  task automatic applyStimulus(input bit rstN, input bit stall, input bit pt,
                               input logic [31:0] ppc, input bit exv,
                               input bit isb, input bit isj, input bit act,
                               input logic [31:0] tgt);
    exp_t  e;
    bit    live, misp, upd;
    logic [31:0] redir;
    meta_t blank;
    @(negedge clk);
    reset = rstN; i_stall = stall; i_pred_taken = pt; i_pred_pc = ppc;
    i_ex_valid = exv; i_ex_is_branch = isb; i_ex_is_jalr = isj;
    i_ex_actual_taken = act; i_ex_target = tgt;
    blank = '{v: 0, pc: 0, pt: 0, ppc: 0};
    if (!rstN) begin
      mPc = 32'h0; mId = blank; mEx = blank; mBranches = 0; mMispredicts = 0;
      e = '{pc: 32'h0, flush: 0, upd: 0, act: 0, updPc: 0, bc: 0, mc: 0, mcSmall: 0, bcSmall: 0};
      expQ.push_back(e);
      return;
    end
    live  = mEx.v && exv;
    upd   = live && isb;
    misp  = live && ((isb && ((mEx.pt != act) || (act && mEx.ppc != tgt))) || isj);
    redir = (act || isj) ? tgt : mEx.pc + 32'd4;
    e.pc = mPc; e.flush = misp; e.upd = upd; e.act = upd && act;
    e.updPc = upd ? mEx.pc : 32'h0;
    e.bc = sat(mBranches, 64'hFFFF_FFFF); e.mc = sat(mMispredicts, 64'hFFFF_FFFF);
    e.bcSmall = 2'(sat(mBranches, 3)); e.mcSmall = 2'(sat(mMispredicts, 3));
    expQ.push_back(e);
    if (upd)  mBranches++;
    if (misp) mMispredicts++;
    if (misp) begin
      mPc = redir; mId.v = 0; mEx.v = 0;
    end else if (stall) begin
      mEx.v = 0;
    end else begin
      mEx = mId;
      mId = '{v: 1, pc: mPc, pt: pt, ppc: ppc};
      mPc = pt ? ppc : mPc + 32'd4;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs before the edge.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("pc", o_pc, e.pc);
      checkOutput("flush", 32'(o_flush), 32'(e.flush));
      checkOutput("update_en", 32'(o_update_en), 32'(e.upd));
      checkOutput("actual_taken", 32'(o_actual_taken), 32'(e.act));
      checkOutput("update_pc", o_update_pc, e.updPc);
      checkOutput("branch_count", o_branch_count, e.bc);
      checkOutput("mispredict_count", o_mispredict_count, e.mc);
      checkOutput("small_branch_count", 32'(s_branch_count), 32'(e.bcSmall));
      checkOutput("small_mispredict_count", 32'(s_mispredict_count), 32'(e.mcSmall));
    end
  end

  initial begin
    bit          stall, pt, exv, isb, isj, act;
    logic [31:0] ppc, tgt;
    int          kind;
    reset = 0; i_stall = 0; i_pred_taken = 0; i_pred_pc = 0; i_ex_valid = 0;
    i_ex_is_branch = 0; i_ex_is_jalr = 0; i_ex_actual_taken = 0; i_ex_target = 0;

    applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 32'h99);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Sequential fetch 0,4,8,12 after release
    repeat (4) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Correctly predicted taken branch at 0x10 -> 0x40
    applyStimulus(1, 0, 1, 32'h40, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 32'h40);
    // Branch at 0x20 predicted not-taken, resolves taken to 0x80
    applyStimulus(1, 0, 1, 32'h20, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 32'h80);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 32'h200);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 32'h200);
    // Branch at 0x30 predicted taken to 0x40, resolves not-taken
    applyStimulus(1, 0, 1, 32'h30, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h40, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 32'h40);
    // JALR redirect while stalled, then the stalled IF/ID entry must be gone
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 1, 0, 32'h100);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 32'h300);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 32'h300);
    // PC wrap from 0xFFFF_FFFC
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      pt    = ($urandom_range(0, 3) == 0);
      ppc   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      exv   = ($urandom_range(0, 7) != 0);
      kind  = $urandom_range(0, 3);
      isb   = (kind == 1) || (kind == 3);
      isj   = (kind == 2);
      act   = $urandom_range(0, 1);
      tgt   = $urandom_range(0, 1) ? mEx.ppc : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      applyStimulus(($urandom_range(0, 80) != 0), stall, pt, ppc, exv, isb, isj, act, tgt);
    end

    @(negedge clk);
    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
    #6;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-stage PC generator and branch-outcome bookkeeper; drives the fetch PC into imem and branch_control, consumes branch_control's prediction, and resolves it when the branch reaches EX.
- Carries each fetched instruction's {pc, pred_taken, pred_pc} through IF/ID and ID/EX shadow registers.
- On a wrong prediction, redirects fetch and flushes the younger stages.
- Drives update_en/actual_taken to branch_predictor_2bit.
- Keeps saturating branch and mispredict performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_stall  in  1  load-use stall from hazard unit.
- o_pc  out  32  current fetch PC.
- i_pred_taken  in  1  branch_taken from branch_control for o_pc.
- i_pred_pc  in  32  branch_pc from branch_control for o_pc.
- i_ex_valid  in  1  EX holds a real instruction.
- i_ex_is_branch  in  1  EX instruction is conditional (opcode 11000).
- i_ex_is_jalr  in  1  EX instruction is JALR.
- i_ex_actual_taken  in  1  resolved condition.
- i_ex_target  in  32  resolved target.
- o_flush  out  1  kill the IF/ID and ID/EX contents.
- o_update_en  out  1  predictor update strobe.
- o_actual_taken  out  1  predictor training value.
- o_update_pc  out  32  PC of the branch being trained.
- o_branch_count  out  CNT_WIDTH  resolved conditional branches.
- o_mispredict_count  out  CNT_WIDTH  redirects taken.

Behaviour:
- Reset (async, reset=0) sets:
  - pc to RESET_PC;
  - both shadow valids to 0;
  - both counters to 0.
- Consequently o_flush, o_update_en and o_actual_taken read 0 while in reset.
- Shadow register pipeline:
  - sh_id holds {v, pc, pred_taken, pred_pc} captured from IF.
  - sh_ex holds the same fields, taken from sh_id.
- ex_live = sh_ex.v & i_ex_valid.
- Mispredict, evaluated combinationally in the EX cycle:
  - conditional branch: ex_live & i_ex_is_branch & ((pred_taken != i_ex_actual_taken) | (i_ex_actual_taken & pred_pc != i_ex_target));
  - JALR: ex_live & i_ex_is_jalr always redirects, since it is never predicted.
- JAL is predicted taken with an exact target in IF, so it never mispredicts and never trains the predictor.
- redirect_pc:
  - i_ex_actual_taken | i_ex_is_jalr selects i_ex_target;
  - otherwise sh_ex.pc + 4.
- o_flush equals mispredict, same cycle (combinational).
- o_update_en = ex_live & i_ex_is_branch, same cycle.
- o_actual_taken = i_ex_actual_taken and o_update_pc = sh_ex.pc; both read 0 when o_update_en = 0.
- next PC, priority order:
  1. mispredict selects redirect_pc;
  2. i_stall holds pc;
  3. i_pred_taken selects i_pred_pc;
  4. otherwise pc + 4.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Shadow update per edge:
  - mispredict: sh_id.v = 0 and sh_ex.v = 0 (flush wins over stall);
  - i_stall: sh_id holds, sh_ex.v = 0 (bubble);
  - otherwise: sh_id takes {1, pc, i_pred_taken, i_pred_pc}, and sh_ex takes sh_id.
- The EX branch resolves even while i_stall is high, because stall only freezes IF/ID.
- Counters, one edge after the event:
  - o_branch_count increments on o_update_en;
  - o_mispredict_count increments on mispredict;
  - both saturate at all-ones and never wrap.
- A reset asserted mid-operation discards all in-flight state immediately; a pending redirect is lost.

Decomposition:
- Shared package rv_pkg:
  - opcode[6:2] constants: OP_BRANCH = 5'b11000, OP_JAL = 5'b11011, OP_JALR = 5'b11001;
  - typedef fetch_meta_t = {v, pc, pred_taken, pred_pc};
  - constant INSTR_BYTES = 4.
- One sub-module, sat_counter (parameter WIDTH, with en and async active-low reset), instantiated twice.

Test Plan:
1. Reset then release with no predictions: o_pc goes 0, 4, 8, 12 on successive edges; flush stays 0 and both counters stay 0.
2. Predicted-taken branch at pc 0x10 (pred_pc 0x40):
   - o_pc goes 0x10 then 0x40.
   - Two cycles later EX reports is_branch=1, actual_taken=1, target=0x40.
   - Required: o_update_en=1, o_update_pc=0x10, o_flush=0, branch_count=1.
3. Branch at pc 0x20 predicted not-taken, resolved taken to 0x80:
   - o_flush=1 in the EX cycle and o_pc=0x80 next edge.
   - Both shadow valids are 0 next cycle.
   - mispredict_count=1.
4. Branch predicted taken to 0x40, resolved not-taken, sh_ex.pc=0x30:
   - redirect to 0x34 and flush=1.
   - o_actual_taken=0 with update_en=1.
5. Redirect coincident with i_stall=1:
   - o_pc takes redirect_pc.
   - sh_id.v=0, so the stall is overridden.
6. Counter saturation with CNT_WIDTH=2: four mispredicts leave o_mispredict_count=3. Separately, i_pred_pc=32'hFFFF_FFFC followed by a not-taken fetch gives o_pc=0.
